// File: rtl/arcade_input_pkg.sv
// Shared types for the arcade player-input front end:
// key-map entry layout, scan FSM states, map byte1 field positions.
package arcade_input_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic [1:0] player;
    logic [3:0] btn;
  } map_entry_t;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } scan_state_e;

  localparam int B1_EXT = 7;
  localparam int B1_PL  = 5;
  localparam int B1_BTN = 0;

endpackage

// File: rtl/input_pulse_shaper.sv
// Per-button output shaping: pass-through, autofire or coin stretch.
// One counter serves whichever mode is active; coin wins over autofire.
module input_pulse_shaper #(
  parameter int COIN_PULSE = 2450000,
  parameter int AF_HALF    = 1225000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic autofire_en,
  input  logic coin_en,
  output logic shaped
);

  localparam int MAXC  = (COIN_PULSE > AF_HALF) ? COIN_PULSE : AF_HALF;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic             raw_q;
  logic             af_off;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    shaped = raw;
    if (coin_en)
      shaped = raw | (cnt != '0);
    else if (autofire_en)
      shaped = raw & ~af_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= 1'b0;
      af_off <= 1'b0;
      cnt    <= '0;
    end else begin
      raw_q <= raw;
      if (coin_en) begin
        af_off <= 1'b0;
        if (raw && !raw_q)
          cnt <= CNT_W'(COIN_PULSE);
        else if (cnt != '0)
          cnt <= cnt - CNT_W'(1);
      end else if (autofire_en) begin
        if (!raw) begin
          cnt    <= '0;
          af_off <= 1'b0;
        end else if (cnt == CNT_W'(AF_HALF - 1)) begin
          cnt    <= '0;
          af_off <= ~af_off;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt    <= '0;
        af_off <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events (via a downloadable key map) and HPS joysticks
// into registered active-low per-player button vectors.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BTNS    = 16,
  parameter int MAP_DEPTH   = 32,
  parameter int MAP_INDEX   = 3,
  parameter int COIN_PULSE  = 2450000,
  parameter int AF_HALF     = 1225000
) (
  input  logic                              clk_49m,
  input  logic                              reset,
  input  logic [10:0]                       ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]         joystick,
  input  logic                              ioctl_download,
  input  logic [7:0]                        ioctl_index,
  input  logic                              ioctl_wr,
  input  logic [24:0]                       ioctl_addr,
  input  logic [7:0]                        ioctl_dout,
  input  logic [NUM_BTNS-1:0]               autofire_mask,
  input  logic [NUM_BTNS-1:0]               coin_mask,
  output logic [NUM_PLAYERS*NUM_BTNS-1:0]   btn_n,
  output logic [$clog2(MAP_DEPTH):0]        map_count,
  output logic                              busy
);

  localparam int AW = $clog2(MAP_DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = NUM_PLAYERS * NUM_BTNS;
  localparam logic [24:0] TBL_END = 25'(2 * MAP_DEPTH);

  logic          map_sel, dl_q, dl_rise, wr_ok, ram_we;
  logic [AW-1:0] widx;
  logic [CW-1:0] cnt_base, widx_p1;
  logic [7:0]    byte0;
  map_entry_t    wr_entry;
  map_entry_t    ram [MAP_DEPTH];
  map_entry_t    rd_q;
  logic          rd_en, rd_vld;

  assign map_sel = ioctl_download && (ioctl_index == 8'(MAP_INDEX));
  assign dl_rise = map_sel && !dl_q;
  assign wr_ok   = map_sel && ioctl_wr && (ioctl_addr < TBL_END);
  assign ram_we  = wr_ok && ioctl_addr[0];
  assign widx    = ioctl_addr[AW:1];
  assign widx_p1 = {1'b0, widx} + CW'(1);
  assign cnt_base = dl_rise ? '0 : map_count;

  assign wr_entry = '{
    code:   byte0,
    ext:    ioctl_dout[B1_EXT],
    player: ioctl_dout[B1_PL +: 2],
    btn:    ioctl_dout[B1_BTN +: 4]
  };

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      dl_q      <= 1'b0;
      byte0     <= '0;
      map_count <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (wr_ok && !ioctl_addr[0])
        byte0 <= ioctl_dout;
      if (ram_we && (widx_p1 > cnt_base))
        map_count <= widx_p1;
      else
        map_count <= cnt_base;
    end
  end

  // Single port: a map write takes the cycle, the scan read waits.
  logic [CW-1:0] idx;

  always_ff @(posedge clk_49m) begin
    if (ram_we)
      ram[widx] <= wr_entry;
    else if (rd_en)
      rd_q <= ram[idx[AW-1:0]];
  end

  logic       tog_q, pend_vld, pend_take;
  logic [9:0] pend;

  scan_state_e   state_q, state_d;
  logic          scan_go;
  logic [CW-1:0] scan_cnt;
  logic [9:0]    scan_key;
  logic [NB-1:0] key_state;
  logic [NB-1:0] shaped;

  assign pend_take = (state_q == S_IDLE) && pend_vld;
  assign busy      = (state_q == S_SCAN);

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      tog_q    <= 1'b0;
      pend_vld <= 1'b0;
      pend     <= '0;
    end else begin
      tog_q <= ps2_key[10];
      if (ps2_key[10] != tog_q) begin
        pend_vld <= 1'b1;
        pend     <= ps2_key[9:0];
      end else if (pend_take) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scan_go = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_vld && (map_count != '0)) begin
          state_d = S_SCAN;
          scan_go = 1'b1;
        end
      end
      S_SCAN: begin
        if (idx == scan_cnt)
          state_d = S_IDLE;
        else
          rd_en = !ram_we;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx       <= '0;
      scan_cnt  <= '0;
      scan_key  <= '0;
      rd_vld    <= 1'b0;
      key_state <= '0;
    end else begin
      state_q <= state_d;
      rd_vld  <= rd_en;
      if (scan_go) begin
        idx      <= '0;
        scan_cnt <= map_count;
        scan_key <= pend;
      end else if (rd_en) begin
        idx <= idx + CW'(1);
      end
      if (rd_vld && (rd_q.code == scan_key[7:0]) && (rd_q.ext == scan_key[8])) begin
        for (int p = 0; p < NUM_PLAYERS; p++)
          for (int b = 0; b < NUM_BTNS; b++)
            if (int'(rd_q.player) == p && int'(rd_q.btn) == b)
              key_state[p*NUM_BTNS + b] <= scan_key[9];
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_btn
    localparam int P = g / NUM_BTNS;
    localparam int B = g % NUM_BTNS;
    input_pulse_shaper #(
      .COIN_PULSE(COIN_PULSE),
      .AF_HALF   (AF_HALF)
    ) u_shaper (
      .clk        (clk_49m),
      .rst_n      (reset),
      .raw        (key_state[g] | joystick[16*P + B]),
      .autofire_en(autofire_mask[B]),
      .coin_en    (coin_mask[B]),
      .shaped     (shaped[g])
    );
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset)
      btn_n <= '1;
    else
      btn_n <= ~shaped;
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: key map load, scan, joystick,
// coin stretch, autofire, write contention and reset mid-scan.
module tb_arcade_input_mapper;

  localparam logic [31:0] ALL1  = 32'hFFFF_FFFF;
  localparam logic [31:0] E075  = 32'hFFF7_FFF7;
  localparam logic [31:0] K16   = 32'hFFFF_FFBF;
  localparam logic [31:0] BOTH  = 32'hFFF7_FFB7;
  localparam logic [31:0] J18   = 32'hFFFB_FFFF;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [31:0] joystick = '0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] autofire_mask = '0;
  logic [15:0] coin_mask = '0;
  wire  [31:0] btn_n;
  wire  [5:0]  map_count;
  wire         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl [6] = '{8'h16, 8'h06, 8'h75, 8'h83, 8'h75, 8'hA3};

  arcade_input_mapper #(
    .NUM_PLAYERS(2),
    .NUM_BTNS   (16),
    .MAP_DEPTH  (32),
    .MAP_INDEX  (3),
    .COIN_PULSE (100),
    .AF_HALF    (10)
  ) dut (
    .clk_49m       (clk_49m),
    .reset         (reset),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .autofire_mask (autofire_mask),
    .coin_mask     (coin_mask),
    .btn_n         (btn_n),
    .map_count     (map_count),
    .busy          (busy)
  );

  always #5 clk_49m = ~clk_49m;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic send_key(input logic pr, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_for(input logic [31:0] exp, input int lim, output int n);
    n = lim + 1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (btn_n === exp) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (btn_n !== ALL1 || busy !== 1'b0 || map_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_hold: btn_n=%h busy=%b cnt=%0d want ffffffff 0 0", btn_n, busy, map_count);
    end
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (btn_n !== ALL1 || busy !== 1'b0 || map_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_release: btn_n=%h busy=%b cnt=%0d want ffffffff 0 0", btn_n, busy, map_count);
    end
  endtask

  task automatic test_count_zero();
    logic seen;
    seen = 1'b0;
    send_key(1'b1, 1'b0, 8'h16);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL count0_busy: busy seen=%b want 0", seen);
    end
    checks++;
    if (btn_n !== ALL1) begin
      errors++;
      $display("FAIL count0_btn: btn_n=%h want ffffffff", btn_n);
    end
    send_key(1'b0, 1'b0, 8'h16);
    repeat (4) tick();
  endtask

  task automatic test_load_map();
    ioctl_index = 8'd3;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) wr_byte(i, tbl[i]);
    wr_byte(64, 8'h16);
    wr_byte(65, 8'h06);
    tick();
    ioctl_download = 1'b0;
    tick();
    checks++;
    if (map_count !== 6'd3) begin
      errors++;
      $display("FAIL load_count: map_count=%0d want 3", map_count);
    end
  endtask

  task automatic test_key_press();
    int n;
    send_key(1'b1, 1'b1, 8'h75);
    wait_for(E075, 7, n);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL press_e075: btn_n=%h want %h within 7", btn_n, E075);
    end
    send_key(1'b0, 1'b1, 8'h75);
    wait_for(ALL1, 7, n);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL release_e075: btn_n=%h want ffffffff", btn_n);
    end
    send_key(1'b1, 1'b0, 8'h16);
    wait_for(K16, 7, n);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL press_16: btn_n=%h want %h", btn_n, K16);
    end
    send_key(1'b0, 1'b0, 8'h16);
    wait_for(ALL1, 7, n);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL release_16: btn_n=%h want ffffffff", btn_n);
    end
    send_key(1'b1, 1'b0, 8'h75);
    repeat (10) tick();
    checks++;
    if (btn_n !== ALL1) begin
      errors++;
      $display("FAIL nonext_75: btn_n=%h want ffffffff", btn_n);
    end
    send_key(1'b0, 1'b0, 8'h75);
    repeat (10) tick();
  endtask

  task automatic test_joystick();
    joystick[18] = 1'b1;
    checks++;
    if (btn_n !== ALL1) begin
      errors++;
      $display("FAIL joy_early: btn_n=%h want ffffffff", btn_n);
    end
    tick();
    checks++;
    if (btn_n !== J18) begin
      errors++;
      $display("FAIL joy_p1b2: btn_n=%h want %h", btn_n, J18);
    end
    joystick[18] = 1'b0;
    tick();
    checks++;
    if (btn_n !== ALL1) begin
      errors++;
      $display("FAIL joy_release: btn_n=%h want ffffffff", btn_n);
    end
  endtask

  task automatic test_coin();
    int low;
    coin_mask[7] = 1'b1;
    joystick[7] = 1'b1;
    tick();
    joystick[7] = 1'b0;
    low = 0;
    while (btn_n[7] === 1'b0 && low < 400) begin
      low++;
      tick();
    end
    checks++;
    if (low != 101) begin
      errors++;
      $display("FAIL coin_single: low=%0d cycles want 101", low);
    end
    repeat (3) tick();
    joystick[7] = 1'b1;
    tick();
    low = 0;
    for (int c = 1; c < 400; c++) begin
      if (btn_n[7] !== 1'b0) break;
      low++;
      joystick[7] = (c == 50);
      tick();
    end
    joystick[7] = 1'b0;
    checks++;
    if (low != 151) begin
      errors++;
      $display("FAIL coin_retrigger: low=%0d cycles want 151", low);
    end
    coin_mask[7] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_autofire();
    logic exp;
    autofire_mask[4] = 1'b1;
    joystick[4] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = !((k - 1) < 35 && (((k - 1) / 10) % 2) == 0);
      checks++;
      if (btn_n[4] !== exp) begin
        errors++;
        $display("FAIL af_hold k=%0d: btn_n[4]=%b want %b", k, btn_n[4], exp);
      end
      if (k == 35) joystick[4] = 1'b0;
    end
    joystick[4] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = !((k - 1) < 5);
      checks++;
      if (btn_n[4] !== exp) begin
        errors++;
        $display("FAIL af_midrel k=%0d: btn_n[4]=%b want %b", k, btn_n[4], exp);
      end
      if (k == 5) joystick[4] = 1'b0;
    end
    autofire_mask[4] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    logic bz;
    n = 99;
    bz = 1'b0;
    send_key(1'b1, 1'b1, 8'h75);
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) ioctl_download = 1'b1;
      if (c >= 4 && c <= 9) begin
        ioctl_addr = 25'(c - 4);
        ioctl_dout = tbl[c-4];
        ioctl_wr = 1'b1;
      end
      if (c == 10) begin
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
      end
      tick();
      if (c == 3) bz = busy;
      if (n == 99 && btn_n === E075) n = c;
    end
    checks++;
    if (bz !== 1'b1) begin
      errors++;
      $display("FAIL burst_busy: busy=%b want 1", bz);
    end
    checks++;
    if (n > 10) begin
      errors++;
      $display("FAIL burst_match: btn_n=%h want %h within 10", btn_n, E075);
    end
    checks++;
    if (map_count !== 6'd3) begin
      errors++;
      $display("FAIL burst_count: map_count=%0d want 3", map_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    send_key(1'b1, 1'b0, 8'h16);
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midscan_busy: busy=%b want 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (btn_n !== ALL1 || busy !== 1'b0 || map_count !== 6'd0) begin
      errors++;
      $display("FAIL midscan_reset: btn_n=%h busy=%b cnt=%0d want ffffffff 0 0", btn_n, busy, map_count);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if (btn_n !== ALL1 || map_count !== 6'd0) begin
      errors++;
      $display("FAIL after_reset: btn_n=%h cnt=%0d want ffffffff 0", btn_n, map_count);
    end
    ioctl_download = 1'b1;
    tick();
    wr_byte(4, tbl[4]);
    wr_byte(5, tbl[5]);
    ioctl_download = 1'b0;
    tick();
    checks++;
    if (map_count !== 6'd3) begin
      errors++;
      $display("FAIL ram_keep_count: map_count=%0d want 3", map_count);
    end
    send_key(1'b1, 1'b0, 8'h16);
    wait_for(K16, 7, n);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL ram_keep_e0: btn_n=%h want %h", btn_n, K16);
    end
    send_key(1'b1, 1'b1, 8'h75);
    wait_for(BOTH, 7, n);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL ram_keep_e1: btn_n=%h want %h", btn_n, BOTH);
    end
  endtask

  initial begin
    test_reset();
    test_count_zero();
    test_load_map();
    test_key_press();
    test_joystick();
    test_coin();
    test_autofire();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
